// File: rtl/coil_chopper_ctrl.sv
// Constant-off-time current chopper for one H-bridge coil.
// Sequences the four gates through IDLE / DEAD / DRIVE / DECAY with leading-edge
// blanking on the current comparator and break-before-make dead time.
module coil_chopper_ctrl #(
    parameter int unsigned DEADTIME = 3,
    parameter int unsigned BLANK_W  = 8,
    parameter int unsigned OFF_W    = 10
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic               polarity,
    input  logic               decay_mode,
    input  logic               analog_cmp,
    input  logic [BLANK_W-1:0] blank_time,
    input  logic [OFF_W-1:0]   off_time,
    output logic               high_1,
    output logic               low_1,
    output logic               high_2,
    output logic               low_2,
    output logic [1:0]         state,
    output logic               chop
);

    // Dead counter only needs to hold DEADTIME-1.
    localparam int unsigned DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DECAY = 2'd3
    } state_t;

    state_t             st_q;
    state_t             pend_q;
    logic [DEAD_W-1:0]  dead_cnt_q;
    logic [BLANK_W-1:0] blank_q;
    logic [OFF_W-1:0]   off_q;
    logic               pol_q;
    logic               chop_q;
    logic [3:0]         gates_q;   // {high_1, low_1, high_2, low_2}

    // Gate pattern for a phase; non-conducting phases map to all-off.
    function automatic logic [3:0] gate_pat(input state_t s, input logic pol, input logic fast);
        logic [3:0] g;
        g = 4'b0000;
        case (s)
            ST_DRIVE: g = pol ? 4'b0110 : 4'b1001;
            ST_DECAY: begin
                if (!fast) g = 4'b0101;
                else       g = pol ? 4'b1001 : 4'b0110;
            end
            default:  g = 4'b0000;
        endcase
        return g;
    endfunction

    // Chopper sequencer; gates are loaded together with the state they belong to.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            st_q       <= ST_IDLE;
            pend_q     <= ST_IDLE;
            dead_cnt_q <= '0;
            blank_q    <= '0;
            off_q      <= '0;
            pol_q      <= 1'b0;
            chop_q     <= 1'b0;
            gates_q    <= 4'b0000;
        end else begin
            chop_q <= 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (enable) begin
                        st_q       <= ST_DEAD;
                        pend_q     <= ST_DRIVE;
                        dead_cnt_q <= DEAD_LOAD;
                        gates_q    <= 4'b0000;
                    end
                end

                ST_DEAD: begin
                    if (!enable) pend_q <= ST_IDLE;
                    if (dead_cnt_q != '0) begin
                        dead_cnt_q <= dead_cnt_q - DEAD_W'(1);
                    end else if (!enable || pend_q == ST_IDLE) begin
                        st_q    <= ST_IDLE;
                        gates_q <= 4'b0000;
                    end else if (pend_q == ST_DECAY) begin
                        // Decay flavour is captured here and held in the gate register.
                        st_q    <= ST_DECAY;
                        off_q   <= (off_time == '0) ? OFF_W'(1) : off_time;
                        gates_q <= gate_pat(ST_DECAY, pol_q, decay_mode);
                    end else begin
                        st_q    <= ST_DRIVE;
                        pol_q   <= polarity;
                        blank_q <= blank_time;
                        gates_q <= gate_pat(ST_DRIVE, polarity, 1'b0);
                    end
                end

                ST_DRIVE, ST_DECAY: begin
                    if (!enable) begin
                        st_q       <= ST_DEAD;
                        pend_q     <= ST_IDLE;
                        dead_cnt_q <= DEAD_LOAD;
                        gates_q    <= 4'b0000;
                    end else if (polarity != pol_q) begin
                        // Direction change aborts the phase and re-drives with the new polarity.
                        st_q       <= ST_DEAD;
                        pend_q     <= ST_DRIVE;
                        dead_cnt_q <= DEAD_LOAD;
                        gates_q    <= 4'b0000;
                    end else if (st_q == ST_DRIVE) begin
                        if (blank_q != '0) begin
                            blank_q <= blank_q - BLANK_W'(1);
                        end else if (analog_cmp) begin
                            st_q       <= ST_DEAD;
                            pend_q     <= ST_DECAY;
                            dead_cnt_q <= DEAD_LOAD;
                            gates_q    <= 4'b0000;
                            chop_q     <= 1'b1;
                        end
                    end else begin
                        if (off_q <= OFF_W'(1)) begin
                            st_q       <= ST_DEAD;
                            pend_q     <= ST_DRIVE;
                            dead_cnt_q <= DEAD_LOAD;
                            gates_q    <= 4'b0000;
                        end else begin
                            off_q <= off_q - OFF_W'(1);
                        end
                    end
                end

                default: begin
                    st_q    <= ST_IDLE;
                    gates_q <= 4'b0000;
                end
            endcase
        end
    end

    assign {high_1, low_1, high_2, low_2} = gates_q;
    assign state = st_q;
    assign chop  = chop_q;

endmodule
